// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage.
// The result is computed at the accepting edge and committed after a fixed latency.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic [CW-1:0]     count;
   logic [WIDTH-1:0]  pend_hi, pend_lo;
   logic              pend_wr;

   logic [2*WIDTH-1:0]       prod_s, prod_u;
   logic [WIDTH-1:0]         min_val, divisor, q_u, r_u;
   logic signed [WIDTH-1:0]  q_s, r_s;
   logic                     div_zero, div_ovf;
   logic [WIDTH-1:0]         res_hi, res_lo;
   logic                     res_wr;

   // Sign-extended operands make the low 2*WIDTH bits of the product the signed product
   assign prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign min_val  = {1'b1, {(WIDTH-1){1'b0}}};
   assign div_zero = (b == '0);
   assign div_ovf  = (a == min_val) && (b == '1);
   // Divisor is forced to 1 in the cases handled separately so the dividers never see 0 or overflow
   assign divisor  = (div_zero || div_ovf) ? WIDTH'(1) : b;
   assign q_s      = $signed(a) / $signed(divisor);
   assign r_s      = $signed(a) % $signed(divisor);
   assign q_u      = a / divisor;
   assign r_u      = a % divisor;

   always_comb begin
      res_hi = '0;
      res_lo = '0;
      res_wr = 1'b1;
      case (op)
         3'd0: {res_hi, res_lo} = prod_s;
         3'd1: {res_hi, res_lo} = prod_u;
         3'd2: begin
            if (div_zero) res_wr = 1'b0;
            else if (div_ovf) begin
               res_lo = min_val;
               res_hi = '0;
            end else begin
               res_lo = q_s;
               res_hi = r_s;
            end
         end
         3'd3: begin
            if (div_zero) res_wr = 1'b0;
            else begin
               res_lo = q_u;
               res_hi = r_u;
            end
         end
         default: res_wr = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
         hi_out  <= '0;
         lo_out  <= '0;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     3'd0, 3'd1, 3'd2, 3'd3: begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_wr <= res_wr;
                        count   <= op[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                        busy    <= 1'b1;
                        state   <= RUN;
                     end
                     3'd4:    hi_out <= a;
                     3'd5:    lo_out <= a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (count != '0) count <= count - 1'b1;
               else begin
                  if (pend_wr) begin
                     hi_out <= pend_hi;
                     lo_out <= pend_lo;
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: default latencies plus a single-cycle instance.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start2;
   logic [2:0]  op, op2;
   logic [31:0] a, b, a2, b2;
   logic [31:0] hi_out, lo_out, hi2, lo2;
   logic        busy, busy2;

   int total = 0;
   int bad   = 0;
   int n;

   always #5 clk = ~clk;

   md_unit u_dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy)
   );

   md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_fast (
      .clk(clk), .reset(reset), .start(start2), .op(op2), .a(a2), .b(b2),
      .hi_out(hi2), .lo_out(lo2), .busy(busy2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op on the main instance and return how many cycles busy stayed high
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cyc);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 50) begin
         cyc++;
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      start2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
      tick(); tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi_out, 32'd0);
      chk("rst_lo", lo_out, 32'd0);
      reset = 1'b0;
      tick();

      // reset in the middle of a DIVU aborts it
      issue(3'd4, 32'h99, 32'h0, n);
      chk("mthi_99", hi_out, 32'h99);
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("divu_running", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi_out, 32'd0);
      chk("abort_lo", lo_out, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      issue(3'd5, 32'd7, 32'd0, n);
      chk("mtlo_7", lo_out, 32'd7);
      repeat (12) tick();
      chk("no_late_commit_hi", hi_out, 32'd0);
      chk("no_late_commit_lo", lo_out, 32'd7);

      // multiply
      issue(3'd0, 32'hFFFF_FFFF, 32'h3, n);
      chk("mult_cycles", n, 32'd5);
      chk("mult_hi", hi_out, 32'hFFFF_FFFF);
      chk("mult_lo", lo_out, 32'hFFFF_FFFD);
      issue(3'd1, 32'hFFFF_FFFF, 32'h3, n);
      chk("multu_hi", hi_out, 32'h2);
      chk("multu_lo", lo_out, 32'hFFFF_FFFD);

      // divide
      issue(3'd2, 32'hFFFF_FFF9, 32'h2, n);
      chk("div_cycles", n, 32'd10);
      chk("div_lo", lo_out, 32'hFFFF_FFFD);
      chk("div_hi", hi_out, 32'hFFFF_FFFF);
      issue(3'd3, 32'd7, 32'd2, n);
      chk("divu_lo", lo_out, 32'd3);
      chk("divu_hi", hi_out, 32'd1);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
      chk("div_ovf_lo", lo_out, 32'h8000_0000);
      chk("div_ovf_hi", hi_out, 32'd0);

      // divide by zero leaves HI/LO alone
      issue(3'd4, 32'h11, 32'h0, n);
      issue(3'd5, 32'h22, 32'h0, n);
      issue(3'd3, 32'd1234, 32'd0, n);
      chk("div0_cycles", n, 32'd10);
      chk("div0_hi", hi_out, 32'h11);
      chk("div0_lo", lo_out, 32'h22);

      // ops issued while busy are ignored; operands only matter at acceptance
      start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
      tick();
      op = 3'd4; a = 32'h55;
      tick();
      start = 1'b0;
      chk("busy_mthi_ignored", hi_out, 32'h11);
      chk("hold_lo", lo_out, 32'h22);
      a = 32'h1234; b = 32'h1234;
      tick(); tick(); tick();
      chk("still_busy", {31'd0, busy}, 32'd1);
      start = 1'b1; op = 3'd5; a = 32'h77;
      tick();
      start = 1'b0;
      chk("commit_busy", {31'd0, busy}, 32'd0);
      chk("commit_lo", lo_out, 32'd42);
      chk("commit_hi", hi_out, 32'd0);
      tick();
      chk("commit_start_ignored_lo", lo_out, 32'd42);
      chk("commit_start_ignored_busy", {31'd0, busy}, 32'd0);

      // single-cycle instance, start held across the commit edge
      start2 = 1'b1; op2 = 3'd0; a2 = 32'd6; b2 = 32'd7;
      tick();
      chk("fast_busy", {31'd0, busy2}, 32'd1);
      op2 = 3'd3; a2 = 32'd100; b2 = 32'd7;
      tick();
      chk("fast_done", {31'd0, busy2}, 32'd0);
      chk("fast_lo", lo2, 32'd42);
      chk("fast_hi", hi2, 32'd0);
      tick();
      start2 = 1'b0;
      chk("fast_b2b_busy", {31'd0, busy2}, 32'd1);
      tick();
      chk("fast_b2b_done", {31'd0, busy2}, 32'd0);
      chk("fast_b2b_lo", lo2, 32'd14);
      chk("fast_b2b_hi", hi2, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
- Runs MULT/MULTU/DIV/DIVU over a configurable number of cycles and asserts busy while it runs.
- Also serves MTHI/MTLO writes and HI/LO reads.
- The hazard unit stalls any HI/LO-touching instruction in D while start or busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, cycles from an accepted MULT/MULTU to result commit (>=1)
DIV_CYCLES, 10, cycles from an accepted DIV/DIVU to result commit (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  issue request; sampled at the rising edge
op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=reserved (ignored)
a  input  WIDTH  rs operand
b  input  WIDTH  rt operand
hi_out  output  WIDTH  current HI register
lo_out  output  WIDTH  current LO register
busy  output  1  operation in flight

Behaviour:
- Reset values:
  - hi_out=0, lo_out=0, busy=0.
  - Internal counter=0, pending HI=0, pending LO=0.
  - State=IDLE.
  - An assertion mid-operation aborts the operation immediately; the result is never committed.
- States: IDLE, RUN.
- IDLE, start=1 at edge t with op in {0..3}:
  - Compute the result from a and b at edge t and latch it into the pending HI/LO registers.
  - Load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES); go to RUN.
  - busy=1 from after edge t.
- RUN, each edge:
  - counter!=0: decrement.
  - counter==0: copy pending to HI/LO, busy=0, go to IDLE.
  - Result: new HI/LO and busy=0 appear together after edge t+N; busy is high for exactly N cycles.
- IDLE, start=1 with op=4 (MTHI) or op=5 (MTLO):
  - HI (resp. LO) <= a at that edge; busy stays 0.
  - The other register is unchanged.
- start with op 6/7: no effect.
- start=1 while busy: ignored (no restart, no MTHI/MTLO write). Preventing this is the hazard unit's contract; the unit does not rely on it.
- start in the same cycle the commit happens (busy still 1): ignored.
- Arithmetic:
  - MULT: signed WIDTH x WIDTH -> 2*WIDTH product; HI=upper WIDTH bits, LO=lower WIDTH bits.
  - MULTU: same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV with a = -2^(WIDTH-1) and b = -1: LO = -2^(WIDTH-1), HI = 0.
  - DIV/DIVU with b=0: busy runs the full DIV_CYCLES; HI and LO are NOT modified at commit.
- Operands are used only at the accepting edge; changes to a/b during RUN do not affect the result.
- hi_out/lo_out are registered outputs:
  - They hold old values throughout RUN.
  - They change only at commit, at an MTHI/MTLO edge, or on reset.

Test Plan:
- Reset mid-run: assert reset 2 cycles after a DIVU start -> busy=0, hi_out=lo_out=0 immediately. After release, MTLO a=7 -> lo_out=7.
- MULT a=0xFFFFFFFF (-1), b=0x00000003, defaults -> busy high exactly 5 cycles; then hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFD. MULTU with the same operands -> hi_out=0x00000002, lo_out=0xFFFFFFFD.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy high exactly 10 cycles; then lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo_out=3, hi_out=1.
- Edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
  - After MTHI a=0x11 and MTLO a=0x22, DIVU b=0 -> busy high 10 cycles; hi_out=0x11, lo_out=0x22 unchanged.
- Issue while busy:
  - During MULT RUN, pulse start with op=4, a=0x55 -> hi_out not written.
  - Change a/b mid-run -> the final result matches the original operands.
  - start on the commit cycle -> ignored.
- Parameter sweep MULT_CYCLES=1, DIV_CYCLES=1: MULT 6x7 -> busy high one cycle, then lo_out=42, hi_out=0. Back-to-back start on the next free edge -> accepted.
